parity_frame_rx: RTL

//  Serial receive/check side of the XOR parity generators (XOR2/3/5).
//  - Accepts a framed bit stream: DATA_BITS data bits, LSB first, then one parity bit.
//  - Reassembles the data word, recomputes parity and flags mismatches.
//  - Presents each word on a valid/ready output port with a one-entry holding register.

---
 rtl/parity_frame_rx_if.sv | 43 ++++
 rtl/parity_frame_rx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/parity_frame_rx_if.sv
// ----------------------------------------------------------------------------
// parity_frame_rx_if
//   Bundles the serial input stream and the valid/ready word output of the
//   parity frame receiver.
//
//   Input stream (driven by the master):
//     in_valid   qualifies in_sof / in_bit for the current cycle
//     in_sof     marks in_bit as data bit 0 of a new frame
//     in_bit     serial data or parity bit
//   Output side:
//     out_valid  out_data / out_err hold a received frame   (receiver drives)
//     out_ready  consumer accepts when out_valid && out_ready (master drives)
//     out_data   reassembled word, bit0 = first bit received (receiver drives)
//     out_err    parity mismatch flag for out_data           (receiver drives)
//     abort      1-cycle pulse: partial frame discarded      (receiver drives)
//     overrun    1-cycle pulse: unread frame overwritten     (receiver drives)
//
//   The slave modport is the receiver's view; the master modport is the view of
//   whatever feeds bits in and consumes words.
// ----------------------------------------------------------------------------
interface parity_frame_rx_if #(
    parameter int DATA_BITS = 5
);
    logic                 in_valid;
    logic                 in_sof;
    logic                 in_bit;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_err;
    logic                 abort;
    logic                 overrun;

    modport master (
        output in_valid, in_sof, in_bit, out_ready,
        input  out_valid, out_data, out_err, abort, overrun
    );

    modport slave (
        input  in_valid, in_sof, in_bit, out_ready,
        output out_valid, out_data, out_err, abort, overrun
    );
endinterface

// File: rtl/parity_frame_rx.sv
// ----------------------------------------------------------------------------
// parity_frame_rx
//   Receives framed serial bits (DATA_BITS data bits LSB first, then one
//   parity bit), reassembles the word, recomputes parity and presents the
//   result through a one-entry valid/ready holding register.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous reset, active-high
//     bus   parity_frame_rx_if.slave (serial input, word output, status pulses)
//
//   Parameters:
//     DATA_BITS   data bits per frame (>= 1), parity bit is extra
//     ODD_PARITY  0: XOR of data and parity must be 0; 1: it must be 1
// ----------------------------------------------------------------------------
module parity_frame_rx #(
    parameter int DATA_BITS  = 5,
    parameter int ODD_PARITY = 0
) (
    input  logic               clk,
    input  logic               rst,
    parity_frame_rx_if.slave   bus
);
    localparam int             CW   = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]  LAST = CW'(DATA_BITS - 1);
    localparam logic           ODD  = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 par_q, par_d;
    logic                 complete;
    logic                 frame_err;
    logic                 abort_d;

    logic                 out_valid_q;
    logic [DATA_BITS-1:0] out_data_q;
    logic                 out_err_q;
    logic                 abort_q;
    logic                 overrun_q;

    // Next-state / datapath decode. Only cycles with in_valid move anything.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        par_d     = par_q;
        complete  = 1'b0;
        frame_err = 1'b0;
        abort_d   = 1'b0;

        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // A start bit always begins a fresh frame; if one was in
                // progress it is dropped and reported.
                abort_d = (state_q != IDLE);
                shift_d = DATA_BITS'(bus.in_bit);
                par_d   = bus.in_bit;
                count_d = CW'(1);
                if (DATA_BITS == 1) state_d = PAR;
                else                state_d = DATA;
            end else begin
                unique case (state_q)
                    IDLE: ;  // stray bit outside a frame: ignored
                    DATA: begin
                        // shift_q was cleared at sof, so OR-ing places the bit
                        shift_d = shift_q | (DATA_BITS'(bus.in_bit) << count_q);
                        par_d   = par_q ^ bus.in_bit;
                        count_d = count_q + CW'(1);
                        if (count_q == LAST) state_d = PAR;
                    end
                    PAR: begin
                        complete  = 1'b1;
                        frame_err = par_q ^ bus.in_bit ^ ODD;
                        state_d   = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Frame assembly state.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            par_q   <= par_d;
        end
    end

    // One-entry output holding register plus status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            abort_q   <= abort_d;
            overrun_q <= 1'b0;
            if (complete) begin
                // A held word that is being accepted this same cycle is not lost.
                out_valid_q <= 1'b1;
                out_data_q  <= shift_q;
                out_err_q   <= frame_err;
                overrun_q   <= out_valid_q && !bus.out_ready;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.abort     = abort_q;
    assign bus.overrun   = overrun_q;

endmodule
